prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader and core-reset sequencer for the single-cycle RISC-V core. Accepts a byte stream (2-byte little-endian word-count header, then little-endian instruction words), writes each assembled word into instruction memory through a dedicated write port, and holds the core in reset until the whole image is written. After the load completes it releases the core. It also supports a reload on request.

## Interface
- IMEM_DEPTH, 256: instruction memory depth in 32-bit words.
- ADDR_W, 8: word-address width, equal to clog2(IMEM_DEPTH).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- rx_valid  in  1  byte-stream valid.
- rx_data  in  8  byte-stream data.
- rx_ready  out  1  byte-stream ready; a byte transfers on a rising edge with rx_valid & rx_ready.
- load_req  in  1  request a reload; honoured only in RUN.
- imem_we  out  1  instruction-memory write strobe, one-cycle pulse per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- core_rst  out  1  reset to the core, active-high.
- busy  out  1  load in progress (header byte 0 accepted, load not yet complete).
- done  out  1  image loaded and core running.
- err  out  1  header word count exceeds IMEM_DEPTH.

## Operation
- States:
  - HDR0: expect count low byte.
  - HDR1: expect count high byte.
  - DATA: expect instruction bytes.
  - RUN: core released.
  - ERR: bad header.
- HDR0, on accept: latch count[7:0] and go to HDR1.
- HDR1, on accept: latch count[15:8] and evaluate the full 16-bit count N.
  - N == 0: go to RUN.
  - N > IMEM_DEPTH: go to ERR.
  - Otherwise: go to DATA.
- DATA: assemble bytes little-endian (first byte is wdata[7:0]) with a 2-bit byte counter.
  - On the 4th byte accept: register the word, pulse imem_we next cycle with imem_addr = word index, then increment the word index.
  - After N words: go to RUN.
- RUN: core_rst = 0, done = 1, rx_ready = 0.
  - load_req = 1: go to HDR0, clear the word index, byte counter and done; core_rst = 1.
- ERR: rx_ready = 0, err = 1, core_rst = 1. Leaves only on rst. load_req is ignored.
- rx_ready = 1 in HDR0, HDR1 and DATA, including the write-pulse cycle; the stream runs without bubbles.
- load_req is ignored outside RUN.
- The word index is ADDR_W+1 bits wide, so N == IMEM_DEPTH is legal. The last word writes address IMEM_DEPTH-1 and there is no wrap.
- Bytes presented in RUN or ERR are not accepted.

## Timing
Reset values (cycle after rst sampled high):
- State HDR0.
- rx_ready = 1, core_rst = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0.
- busy = 0, done = 0, err = 0.
- Word index and byte counter = 0.

Cycle-level behaviour:
- rst mid-load:
  - Returns to the reset state immediately; any partial word is discarded.
  - Words already written remain in imem; they are not the loader's concern.
  - rst has priority over every other event.
- Write latency: imem_we is high in the cycle after the 4th byte handshake. imem_addr and imem_wdata are stable for that cycle only.
- Load completion:
  - Last write pulse in cycle T: state is RUN in T+1.
  - core_rst falls and done rises in T+1.
  - busy falls in T+1.
- N == 0: HDR1 accept in cycle T gives RUN in T+1. No imem_we.
- ERR: err and rx_ready change in the cycle after the HDR1 accept.
- load_req in RUN at edge T: core_rst = 1 and done = 0 from T+1, rx_ready = 1.
- Gaps in rx_valid stall assembly without losing partial bytes.

## Test plan
- 5-word image, stream 05 00 93 00 50 00 13 01 70 00 B3 81 20 00 23 20 30 00 03 22 00 00 at full rate:
  - Writes 0x00500093, 0x00700113, 0x002081B3, 0x00302023, 0x00002203 to addr 0-4.
  - core_rst falls and done = 1 in the cycle after the 5th imem_we.
- Same image with rx_valid deasserted for 1-3 random cycles between bytes: identical writes, addresses and final state.
- Header 00 00: no imem_we; RUN, core_rst = 0 and done = 1 one cycle after the 2nd byte.
- Header 01 01 (N = 257, IMEM_DEPTH = 256): err = 1, rx_ready = 0, core_rst stays 1, following bytes refused. rst recovers to HDR0.
- rst pulse after 2 words plus 2 bytes of a 5-word load:
  - State HDR0 with all outputs at reset values.
  - A fresh full load then writes addr 0-4 correctly.
- load_req in RUN: core_rst = 1 and done = 0 next cycle. A reload of N = 256 writes addr 0-255 and ends in RUN with no wrap to addr 0.

Source files
------------

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot-time program loader and core-reset sequencer
// Takes a length-prefixed little-endian byte stream, writes words to imem, then releases the core.
module prog_loader #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, RUN, ERR} state_t;

  state_t            state, state_nx;
  logic [7:0]        cnt_lo;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   word_nx;
  logic [1:0]        byte_cnt;
  logic [23:0]       partial;
  logic [15:0]       hdr_n;
  logic              accept;

  assign accept  = rx_valid & rx_ready;
  assign hdr_n   = {rx_data, cnt_lo};
  assign word_nx = word_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= HDR0;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rx_ready = 1'b0;
    core_rst = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      HDR0: begin
        rx_ready = 1'b1;
        if (accept) state_nx = HDR1;
      end
      HDR1: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          if (hdr_n == 16'd0)                   state_nx = RUN;
          else if (hdr_n > 16'(IMEM_DEPTH))     state_nx = ERR;
          else                                  state_nx = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        // Leave only once the final word's write pulse has been issued.
        if (imem_we && (word_nx == count)) state_nx = RUN;
      end
      RUN: begin
        core_rst = 1'b0;
        done     = 1'b1;
        if (load_req) state_nx = HDR0;
      end
      ERR: begin
        err = 1'b1;
      end
      default: state_nx = HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lo     <= '0;
      count      <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      partial    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we) word_idx <= word_nx;
      case (state)
        HDR0: if (accept) cnt_lo <= rx_data;
        HDR1: if (accept) count <= hdr_n[ADDR_W:0];
        DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx[ADDR_W-1:0];
              imem_wdata <= {rx_data, partial};
            end else begin
              case (byte_cnt)
                2'd0:    partial[7:0]   <= rx_data;
                2'd1:    partial[15:8]  <= rx_data;
                default: partial[23:16] <= rx_data;
              endcase
            end
          end
        end
        RUN: begin
          if (load_req) begin
            word_idx <= '0;
            byte_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed, table-driven bench for prog_loader
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        load_req = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst, busy, done, err;

  int errors = 0;
  int checks = 0;

  logic [7:0]  qa[$];
  logic [31:0] qd[$];

  typedef struct {
    logic [31:0] stream;
    logic [31:0] word;
    logic [7:0]  addr;
  } vec_t;
  vec_t vecs[5];

  prog_loader #(.IMEM_DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .load_req(load_req), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      qa.push_back(imem_addr);
      qd.push_back(imem_wdata);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = rx_ready;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_byte: byte 0x%0h not accepted within 20 cycles", b);
    end
  endtask

  task automatic send_words(input int n, input bit gaps, input bit use_tbl);
    logic [31:0] s;
    logic [7:0]  i8;
    for (int w = 0; w < n; w++) begin
      i8 = w[7:0];
      s = use_tbl ? vecs[w].stream : {i8, 8'h5A, ~i8, 8'hC3};
      for (int k = 0; k < 4; k++) begin
        if (gaps) tick($urandom_range(1, 3));
        send_byte(s[31-8*k -: 8]);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " rx_ready"},   32'(rx_ready),   32'd1);
    check({tag, " core_rst"},   32'(core_rst),   32'd1);
    check({tag, " imem_we"},    32'(imem_we),    32'd0);
    check({tag, " imem_addr"},  32'(imem_addr),  32'd0);
    check({tag, " imem_wdata"}, imem_wdata,      32'd0);
    check({tag, " busy"},       32'(busy),       32'd0);
    check({tag, " done"},       32'(done),       32'd0);
    check({tag, " err"},        32'(err),        32'd0);
  endtask

  task automatic check_table(input string tag, input int base);
    check({tag, " write count"}, 32'(qa.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < qa.size()) begin
        check($sformatf("%s addr[%0d]", tag, i), 32'(qa[base+i]), 32'(vecs[i].addr));
        check($sformatf("%s data[%0d]", tag, i), qd[base+i], vecs[i].word);
      end
    end
  endtask

  task automatic do_load_req();
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
  endtask

  initial begin
    int base;
    logic [7:0] i8;
    vecs[0] = '{32'h93005000, 32'h00500093, 8'd0};
    vecs[1] = '{32'h13017000, 32'h00700113, 8'd1};
    vecs[2] = '{32'hB3812000, 32'h002081B3, 8'd2};
    vecs[3] = '{32'h23203000, 32'h00302023, 8'd3};
    vecs[4] = '{32'h03220000, 32'h00002203, 8'd4};

    tick(1);
    check_reset("reset");
    rst = 1'b0;

    // Full-rate 5-word image with write-latency and completion timing
    base = qa.size();
    send_byte(8'h05);
    check("hdr0 busy", 32'(busy), 32'd1);
    send_byte(8'h00);
    send_words(5, 1'b0, 1'b1);
    check("last pulse we",   32'(imem_we),   32'd1);
    check("last pulse addr", 32'(imem_addr), 32'd4);
    check("last pulse core_rst", 32'(core_rst), 32'd1);
    tick(1);
    check("fr core_rst", 32'(core_rst), 32'd0);
    check("fr done",     32'(done),     32'd1);
    check("fr busy",     32'(busy),     32'd0);
    check("fr rx_ready", 32'(rx_ready), 32'd0);
    check_table("fullrate", base);

    // Bytes in RUN are refused
    rx_valid = 1'b1; rx_data = 8'hAA;
    tick(4);
    rx_valid = 1'b0;
    check("run refuse writes", 32'(qa.size() - base), 32'd5);
    check("run refuse done", 32'(done), 32'd1);

    // Reload with random gaps
    do_load_req();
    check("ldreq core_rst", 32'(core_rst), 32'd1);
    check("ldreq done",     32'(done),     32'd0);
    check("ldreq rx_ready", 32'(rx_ready), 32'd1);
    base = qa.size();
    send_byte(8'h05);
    tick($urandom_range(1, 3));
    send_byte(8'h00);
    send_words(5, 1'b1, 1'b1);
    tick(1);
    check("gap done",     32'(done),     32'd1);
    check("gap core_rst", 32'(core_rst), 32'd0);
    check_table("gaps", base);

    // Empty image
    do_load_req();
    base = qa.size();
    send_byte(8'h00);
    send_byte(8'h00);
    check("n0 done",     32'(done),     32'd1);
    check("n0 core_rst", 32'(core_rst), 32'd0);
    check("n0 writes",   32'(qa.size() - base), 32'd0);

    // Oversized header
    do_load_req();
    send_byte(8'h01);
    send_byte(8'h01);
    check("err err",      32'(err),      32'd1);
    check("err rx_ready", 32'(rx_ready), 32'd0);
    check("err core_rst", 32'(core_rst), 32'd1);
    base = qa.size();
    rx_valid = 1'b1; rx_data = 8'h55;
    load_req = 1'b1;
    tick(6);
    rx_valid = 1'b0; load_req = 1'b0;
    check("err sticky",   32'(err),  32'd1);
    check("err busy",     32'(busy), 32'd0);
    check("err writes",   32'(qa.size() - base), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset("err recover");

    // rst after 2 words + 2 bytes, then fresh load
    base = qa.size();
    send_byte(8'h05);
    send_byte(8'h00);
    send_words(2, 1'b0, 1'b1);
    send_byte(8'h03);
    send_byte(8'h22);
    tick(1);
    check("mid writes", 32'(qa.size() - base), 32'd2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset("mid rst");
    base = qa.size();
    send_byte(8'h05);
    send_byte(8'h00);
    send_words(5, 1'b0, 1'b1);
    tick(1);
    check("fresh done", 32'(done), 32'd1);
    check_table("fresh", base);

    // Full-depth reload
    do_load_req();
    check("ld256 core_rst", 32'(core_rst), 32'd1);
    base = qa.size();
    send_byte(8'h00);
    send_byte(8'h01);
    send_words(256, 1'b0, 1'b0);
    tick(1);
    check("n256 done",     32'(done),     32'd1);
    check("n256 core_rst", 32'(core_rst), 32'd0);
    tick(4);
    check("n256 writes", 32'(qa.size() - base), 32'd256);
    begin
      int bad_a, bad_d;
      bad_a = 0; bad_d = 0;
      for (int i = 0; i < 256 && base + i < qa.size(); i++) begin
        i8 = i[7:0];
        if (qa[base+i] !== i8) bad_a++;
        if (qd[base+i] !== {8'hC3, ~i8, 8'h5A, i8}) bad_d++;
      end
      check("n256 addr errs", 32'(bad_a), 32'd0);
      check("n256 data errs", 32'(bad_d), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
